// File: rtl/axi_slave_mem_if.sv
// AXI4 write/read channel bundle for the slave memory.
// The slave modport is used by the memory; the master modport is used by the driver.
interface axi_slave_mem_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 512
);
    logic [ID_W-1:0]     s_axi_awid;
    logic [ADDR_W-1:0]   s_axi_awaddr;
    logic [7:0]          s_axi_awlen;
    logic [1:0]          s_axi_awburst;
    logic                s_axi_awvalid;
    logic                s_axi_awready;
    logic [DATA_W-1:0]   s_axi_wdata;
    logic [DATA_W/8-1:0] s_axi_wstrb;
    logic                s_axi_wlast;
    logic                s_axi_wvalid;
    logic                s_axi_wready;
    logic [ID_W-1:0]     s_axi_bid;
    logic [1:0]          s_axi_bresp;
    logic                s_axi_bvalid;
    logic                s_axi_bready;
    logic [ID_W-1:0]     s_axi_arid;
    logic [ADDR_W-1:0]   s_axi_araddr;
    logic [7:0]          s_axi_arlen;
    logic [1:0]          s_axi_arburst;
    logic                s_axi_arvalid;
    logic                s_axi_arready;
    logic [ID_W-1:0]     s_axi_rid;
    logic [DATA_W-1:0]   s_axi_rdata;
    logic [1:0]          s_axi_rresp;
    logic                s_axi_rlast;
    logic                s_axi_rvalid;
    logic                s_axi_rready;

    modport slave (
        input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awburst, s_axi_awvalid,
        output s_axi_awready,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        output s_axi_wready,
        output s_axi_bid, s_axi_bresp, s_axi_bvalid,
        input  s_axi_bready,
        input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arburst, s_axi_arvalid,
        output s_axi_arready,
        output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        input  s_axi_rready
    );

    modport master (
        output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awburst, s_axi_awvalid,
        input  s_axi_awready,
        output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        input  s_axi_wready,
        input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
        output s_axi_bready,
        output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arburst, s_axi_arvalid,
        input  s_axi_arready,
        input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        output s_axi_rready
    );
endinterface

// File: rtl/axi_slave_mem.sv
// AXI4 slave backed by a MEM_DEPTH x DATA_WIDTH register array, so traffic
// generators can be exercised without the DDR3 controller behind them.
//
// state   | meaning
// W_IDLE  | awready high, waiting for a write address
// W_DATA  | wready high, one memory write per accepted beat
// W_RESP  | bvalid high, response held until bready
// R_IDLE  | arready high, waiting for a read address
// R_FETCH | one cycle to register the addressed word into rdata
// R_DATA  | rvalid high, beat held until rready
module axi_slave_mem #(
    parameter int C_S_AXI_ID_WIDTH   = 4,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 512,
    parameter int MEM_DEPTH          = 256
) (
    input  logic           clk,
    input  logic           rst,
    axi_slave_mem_if.slave s_axi
);
    localparam int STRB_W   = C_S_AXI_DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = $clog2(MEM_DEPTH);
    localparam int AW       = C_S_AXI_ADDR_WIDTH;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

    logic [C_S_AXI_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    w_state_e                    w_state_q, w_state_d;
    logic [C_S_AXI_ID_WIDTH-1:0] w_id_q, w_id_d;
    logic [AW-1:0]               w_addr_q, w_addr_d;
    logic [7:0]                  w_len_q, w_len_d;
    logic [7:0]                  w_cnt_q, w_cnt_d;
    logic                        w_fixed_q, w_fixed_d;
    logic                        w_err_q, w_err_d;
    logic                        awready_q, awready_d;
    logic                        mem_we;
    logic [IDX_W-1:0]            w_idx;
    logic                        w_in_range;

    r_state_e                      r_state_q, r_state_d;
    logic [C_S_AXI_ID_WIDTH-1:0]   r_id_q, r_id_d;
    logic [AW-1:0]                 r_addr_q, r_addr_d;
    logic [7:0]                    r_len_q, r_len_d;
    logic [7:0]                    r_cnt_q, r_cnt_d;
    logic                          r_fixed_q, r_fixed_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]                    rresp_q, rresp_d;
    logic                          rlast_q, rlast_d;
    logic                          arready_q, arready_d;
    logic [IDX_W-1:0]              r_idx;
    logic                          r_in_range;

    always_comb begin
        w_state_d  = w_state_q;
        w_id_d     = w_id_q;
        w_addr_d   = w_addr_q;
        w_len_d    = w_len_q;
        w_cnt_d    = w_cnt_q;
        w_fixed_d  = w_fixed_q;
        w_err_d    = w_err_q;
        mem_we     = 1'b0;
        w_idx      = w_addr_q[ADDR_LSB +: IDX_W];
        w_in_range = (w_addr_q[AW-1:ADDR_LSB+IDX_W] == '0);
        case (w_state_q)
            W_IDLE: begin
                if (s_axi.s_axi_awvalid && awready_q) begin
                    w_id_d    = s_axi.s_axi_awid;
                    w_addr_d  = s_axi.s_axi_awaddr;
                    w_len_d   = s_axi.s_axi_awlen;
                    w_fixed_d = (s_axi.s_axi_awburst == 2'b00);
                    w_cnt_d   = '0;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (s_axi.s_axi_wvalid) begin
                    mem_we = w_in_range;
                    // wlast is only checked; the beat count alone ends the burst
                    if (!w_in_range || (s_axi.s_axi_wlast != (w_cnt_q == w_len_q))) begin
                        w_err_d = 1'b1;
                    end
                    if (w_cnt_q == w_len_q) begin
                        w_state_d = W_RESP;
                    end else begin
                        w_cnt_d = w_cnt_q + 8'd1;
                        if (!w_fixed_q) begin
                            w_addr_d = w_addr_q + AW'(STRB_W);
                        end
                    end
                end
            end
            W_RESP: begin
                if (s_axi.s_axi_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
    end

    always_comb begin
        r_state_d  = r_state_q;
        r_id_d     = r_id_q;
        r_addr_d   = r_addr_q;
        r_len_d    = r_len_q;
        r_cnt_d    = r_cnt_q;
        r_fixed_d  = r_fixed_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rlast_d    = rlast_q;
        r_idx      = r_addr_q[ADDR_LSB +: IDX_W];
        r_in_range = (r_addr_q[AW-1:ADDR_LSB+IDX_W] == '0);
        case (r_state_q)
            R_IDLE: begin
                if (s_axi.s_axi_arvalid && arready_q) begin
                    r_id_d    = s_axi.s_axi_arid;
                    r_addr_d  = s_axi.s_axi_araddr;
                    r_len_d   = s_axi.s_axi_arlen;
                    r_fixed_d = (s_axi.s_axi_arburst == 2'b00);
                    r_cnt_d   = '0;
                    r_state_d = R_FETCH;
                end
            end
            R_FETCH: begin
                rdata_d   = r_in_range ? mem_q[r_idx] : '0;
                rresp_d   = r_in_range ? 2'b00 : 2'b10;
                rlast_d   = (r_cnt_q == r_len_q);
                r_state_d = R_DATA;
            end
            R_DATA: begin
                if (s_axi.s_axi_rready) begin
                    if (rlast_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_cnt_d   = r_cnt_q + 8'd1;
                        r_state_d = R_FETCH;
                        if (!r_fixed_q) begin
                            r_addr_d = r_addr_q + AW'(STRB_W);
                        end
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
    end

    // Ready flags are registered so they stay low while reset is asserted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_fixed_q <= 1'b0;
            w_err_q   <= 1'b0;
            awready_q <= 1'b0;
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_fixed_q <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
            arready_q <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_fixed_q <= w_fixed_d;
            w_err_q   <= w_err_d;
            awready_q <= awready_d;
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_fixed_q <= r_fixed_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            arready_q <= arready_d;
        end
    end

    // Contents survive reset; a same-cycle fetch sees the pre-write word.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi.s_axi_wstrb[b]) begin
                    mem_q[w_idx][b*8 +: 8] <= s_axi.s_axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign s_axi.s_axi_awready = awready_q;
    assign s_axi.s_axi_wready  = (w_state_q == W_DATA);
    assign s_axi.s_axi_bvalid  = (w_state_q == W_RESP);
    assign s_axi.s_axi_bid     = w_id_q;
    assign s_axi.s_axi_bresp   = (w_state_q == W_RESP && w_err_q) ? 2'b10 : 2'b00;
    assign s_axi.s_axi_arready = arready_q;
    assign s_axi.s_axi_rvalid  = (r_state_q == R_DATA);
    assign s_axi.s_axi_rid     = r_id_q;
    assign s_axi.s_axi_rdata   = rdata_q;
    assign s_axi.s_axi_rresp   = rresp_q;
    assign s_axi.s_axi_rlast   = rlast_q;
endmodule

// File: tb/tb_axi_slave_mem.sv
// Bench for axi_slave_mem: directed vector table, reset-mid-burst sequence and
// random bursts checked against a word-array reference model.
module tb_axi_slave_mem;
    localparam int IDW    = 4;
    localparam int AW     = 32;
    localparam int DW     = 512;
    localparam int SW     = DW / 8;
    localparam int DEPTH  = 256;
    localparam int BUDGET = 200;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    axi_slave_mem_if #(.ID_W(IDW), .ADDR_W(AW), .DATA_W(DW)) bus ();

    axi_slave_mem #(
        .C_S_AXI_ID_WIDTH  (IDW),
        .C_S_AXI_ADDR_WIDTH(AW),
        .C_S_AXI_DATA_WIDTH(DW),
        .MEM_DEPTH         (DEPTH)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .s_axi(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] wd [256];
    logic [SW-1:0] ws [256];

    typedef struct {
        bit            is_wr;
        logic [IDW-1:0] id;
        logic [AW-1:0] addr;
        int            len;
        logic [1:0]    burst;
        int            dmode;
        logic [SW-1:0] strb;
        bit            bad_last;
        logic [1:0]    exp_resp;
        bit            chk_data;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timeout after %0d cycles", name, BUDGET);
    endtask

    function automatic logic sig_val(input int which);
        case (which)
            0: return bus.s_axi_awready;
            1: return bus.s_axi_wready;
            2: return bus.s_axi_bvalid;
            3: return bus.s_axi_arready;
            4: return bus.s_axi_rvalid;
            default: return 1'b0;
        endcase
    endfunction

    // Returns at a falling edge with the signal high (or after the budget).
    task automatic wait_for(input int which, input string name);
        bit done = 0;
        int t = 0;
        while (!done) begin
            @(negedge clk);
            if (sig_val(which)) done = 1;
            else if (t++ >= BUDGET) begin
                tmo(name);
                done = 1;
            end
        end
    endtask

    function automatic logic [1:0] model_write(input logic [AW-1:0] addr, input int len,
                                               input logic [1:0] burst, input bit bad_last);
        bit err = bad_last;
        for (int i = 0; i <= len; i++) begin
            longint word = longint'(addr >> 6) + ((burst == 2'b00) ? 0 : i);
            if (word >= DEPTH) err = 1;
            else begin
                for (int b = 0; b < SW; b++)
                    if (ws[i][b]) model_mem[int'(word)][b*8 +: 8] = wd[i][b*8 +: 8];
            end
        end
        return err ? 2'b10 : 2'b00;
    endfunction

    task automatic do_write(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input int len,
                            input logic [1:0] burst, input bit bad_last, input bit hold_b,
                            output logic [1:0] resp);
        logic [1:0] exp;
        exp  = model_write(addr, len, burst, bad_last);
        resp = 2'b11;
        @(posedge clk); #1;
        bus.s_axi_awid    = id;
        bus.s_axi_awaddr  = addr;
        bus.s_axi_awlen   = 8'(len);
        bus.s_axi_awburst = burst;
        bus.s_axi_awvalid = 1'b1;
        wait_for(0, "awready");
        @(posedge clk); #1;
        bus.s_axi_awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            bus.s_axi_wdata  = wd[i];
            bus.s_axi_wstrb  = ws[i];
            bus.s_axi_wlast  = !bad_last && (i == len);
            bus.s_axi_wvalid = 1'b1;
            wait_for(1, "wready");
            @(posedge clk); #1;
            bus.s_axi_wvalid = 1'b0;
            bus.s_axi_wlast  = 1'b0;
        end
        if (!hold_b) begin
            wait_for(2, "bvalid");
            chk("bid", DW'(bus.s_axi_bid), DW'(id));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            resp = bus.s_axi_bresp;
            chk("bresp_model", DW'(resp), DW'(exp));
            chk("bvalid_hold", DW'(bus.s_axi_bvalid), DW'(1'b1));
            bus.s_axi_bready = 1'b1;
            @(posedge clk); #1;
            bus.s_axi_bready = 1'b0;
            chk("awready_after_b", DW'(bus.s_axi_awready), DW'(1'b1));
        end
    endtask

    task automatic do_read(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input int len,
                           input logic [1:0] burst, output logic [DW-1:0] first_data,
                           output logic [1:0] last_resp);
        first_data = '0;
        last_resp  = 2'b11;
        @(posedge clk); #1;
        bus.s_axi_arid    = id;
        bus.s_axi_araddr  = addr;
        bus.s_axi_arlen   = 8'(len);
        bus.s_axi_arburst = burst;
        bus.s_axi_arvalid = 1'b1;
        wait_for(3, "arready");
        @(posedge clk); #1;
        bus.s_axi_arvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            longint word = longint'(addr >> 6) + ((burst == 2'b00) ? 0 : i);
            logic [DW-1:0] exp_d = (word < DEPTH) ? model_mem[int'(word)] : '0;
            logic [1:0]    exp_r = (word < DEPTH) ? 2'b00 : 2'b10;
            int stall = $urandom_range(0, 2);
            wait_for(4, "rvalid");
            for (int s = 0; s < stall; s++) begin
                chk("rdata_hold", bus.s_axi_rdata, exp_d);
                @(negedge clk);
            end
            chk("rdata", bus.s_axi_rdata, exp_d);
            chk("rresp", DW'(bus.s_axi_rresp), DW'(exp_r));
            chk("rlast", DW'(bus.s_axi_rlast), DW'(i == len));
            chk("rid", DW'(bus.s_axi_rid), DW'(id));
            if (i == 0) first_data = bus.s_axi_rdata;
            last_resp = bus.s_axi_rresp;
            bus.s_axi_rready = 1'b1;
            @(posedge clk); #1;
            bus.s_axi_rready = 1'b0;
        end
        chk("arready_after_r", DW'(bus.s_axi_arready), DW'(1'b1));
    endtask

    task automatic rand_beats(input int len);
        for (int i = 0; i <= len; i++) begin
            for (int j = 0; j < DW / 32; j++) wd[i][j*32 +: 32] = $urandom();
            ws[i] = {$urandom(), $urandom()};
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]    resp;
        logic [DW-1:0] rd;
        vec_t          v;

        bus.s_axi_awid = '0; bus.s_axi_awaddr = '0; bus.s_axi_awlen = '0; bus.s_axi_awburst = '0;
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wlast = 1'b0;
        bus.s_axi_wvalid = 1'b0; bus.s_axi_bready = 1'b0; bus.s_axi_arid = '0; bus.s_axi_araddr = '0;
        bus.s_axi_arlen = '0; bus.s_axi_arburst = '0; bus.s_axi_arvalid = 1'b0; bus.s_axi_rready = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_awready", DW'(bus.s_axi_awready), '0);
        chk("rst_arready", DW'(bus.s_axi_arready), '0);
        chk("rst_bvalid", DW'(bus.s_axi_bvalid), '0);
        chk("rst_rvalid", DW'(bus.s_axi_rvalid), '0);
        chk("rst_wready", DW'(bus.s_axi_wready), '0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_awready", DW'(bus.s_axi_awready), DW'(1'b1));
        chk("post_rst_arready", DW'(bus.s_axi_arready), DW'(1'b1));

        // fill the whole array so every model word is defined
        rand_beats(255);
        for (int i = 0; i < 256; i++) ws[i] = '1;
        do_write(4'h0, 32'h0, 255, 2'b01, 1'b0, 1'b0, resp);

        vecs.push_back('{1, 4'h3, 32'h40,   0, 2'b01, 1, '1,     0, 2'b00, 0, '0});
        vecs.push_back('{0, 4'h3, 32'h40,   0, 2'b01, 0, '0,     0, 2'b00, 1, {64{8'hA5}}});
        vecs.push_back('{1, 4'h5, 32'h0,    2, 2'b01, 0, '1,     0, 2'b00, 0, '0});
        vecs.push_back('{0, 4'h6, 32'h0,    2, 2'b01, 0, '0,     0, 2'b00, 0, '0});
        vecs.push_back('{1, 4'h7, 32'h80,   3, 2'b00, 2, '1,     0, 2'b00, 0, '0});
        vecs.push_back('{0, 4'h7, 32'h80,   0, 2'b01, 0, '0,     0, 2'b00, 1, 512'h4});
        vecs.push_back('{1, 4'h1, 32'h80,   0, 2'b01, 3, 64'h1,  0, 2'b00, 0, '0});
        vecs.push_back('{0, 4'h2, 32'h80,   0, 2'b01, 0, '0,     0, 2'b00, 1, 512'hFF});
        vecs.push_back('{0, 4'h2, 32'h80,   2, 2'b00, 0, '0,     0, 2'b00, 1, 512'hFF});
        vecs.push_back('{1, 4'h4, 32'h4000, 0, 2'b01, 0, '1,     0, 2'b10, 0, '0});
        vecs.push_back('{1, 4'h8, 32'h100,  1, 2'b01, 0, '1,     1, 2'b10, 0, '0});
        vecs.push_back('{1, 4'h9, 32'h3FC0, 1, 2'b01, 0, '1,     0, 2'b10, 0, '0});
        vecs.push_back('{0, 4'hA, 32'h3FC0, 1, 2'b01, 0, '0,     0, 2'b10, 0, '0});
        vecs.push_back('{0, 4'hB, 32'h4000, 0, 2'b01, 0, '0,     0, 2'b10, 1, '0});
        vecs.push_back('{1, 4'hC, 32'h3FC0, 2, 2'b10, 0, '1,     0, 2'b10, 0, '0});

        foreach (vecs[k]) begin
            v = vecs[k];
            if (v.is_wr) begin
                rand_beats(v.len);
                for (int i = 0; i <= v.len; i++) begin
                    ws[i] = v.strb;
                    case (v.dmode)
                        1: wd[i] = {64{8'hA5}};
                        2: wd[i] = DW'(i + 1);
                        3: wd[i] = {64{8'hFF}};
                        default: ;
                    endcase
                end
                do_write(v.id, v.addr, v.len, v.burst, v.bad_last, 1'b0, resp);
                chk($sformatf("vec%0d_bresp", k), DW'(resp), DW'(v.exp_resp));
            end else begin
                do_read(v.id, v.addr, v.len, v.burst, rd, resp);
                chk($sformatf("vec%0d_rresp_last", k), DW'(resp), DW'(v.exp_resp));
                if (v.chk_data) chk($sformatf("vec%0d_rdata", k), rd, v.exp_data);
            end
        end

        // reset while a write response and a read beat are both pending
        wd[0] = {16{32'h1234_5678}};
        ws[0] = '1;
        do_write(4'hD, 32'h140, 0, 2'b01, 1'b0, 1'b1, resp);
        wait_for(2, "bvalid_pre_reset");
        @(posedge clk); #1;
        bus.s_axi_arid = 4'hE; bus.s_axi_araddr = 32'h140; bus.s_axi_arlen = 8'd0;
        bus.s_axi_arburst = 2'b01; bus.s_axi_arvalid = 1'b1;
        wait_for(3, "arready_pre_reset");
        @(posedge clk); #1;
        bus.s_axi_arvalid = 1'b0;
        wait_for(4, "rvalid_pre_reset");
        chk("bvalid_pre_reset", DW'(bus.s_axi_bvalid), DW'(1'b1));
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_rvalid", DW'(bus.s_axi_rvalid), '0);
        chk("mid_rst_bvalid", DW'(bus.s_axi_bvalid), '0);
        chk("mid_rst_rdata", bus.s_axi_rdata, '0);
        chk("mid_rst_awready", DW'(bus.s_axi_awready), '0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rel_awready", DW'(bus.s_axi_awready), DW'(1'b1));
        chk("rel_arready", DW'(bus.s_axi_arready), DW'(1'b1));
        do_read(4'hE, 32'h140, 0, 2'b01, rd, resp);
        chk("after_rst_data", rd, {16{32'h1234_5678}});

        // random bursts against the reference model
        for (int n = 0; n < 30; n++) begin
            logic [AW-1:0] a;
            int            ln;
            logic [1:0]    br;
            ln = $urandom_range(0, 7);
            br = 2'($urandom_range(0, 2));
            a  = AW'($urandom_range(0, 263) * 64 + $urandom_range(0, 63));
            rand_beats(ln);
            do_write(4'($urandom()), a, ln, br, ($urandom_range(0, 7) == 0), 1'b0, resp);
            ln = $urandom_range(0, 7);
            br = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 0)
                a = AW'($urandom_range(0, 263) * 64);
            do_read(4'($urandom()), a, ln, br, rd, resp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
